// File: rtl/ieee_to_fphub_conv.sv
// IEEE-754 to HUB operand conversion for the X/Y inputs of the HUB multiplier.
// Two register stages (class decode, then pack) with a lossless valid/ready skid.
module ieee_to_fphub_conv #(
  parameter int M = 23,
  parameter int E = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [E+M:0] in_a,
  input  logic [E+M:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [E+M:0] out_x,
  output logic [E+M:0] out_y,
  output logic [5:0]   out_flags
);
  localparam int W    = 1 + E + M;
  localparam int NOPS = 2;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic maxe;
  } cls_t;

  typedef struct packed {
    logic nan;
    logic sat;
    logic flush;
  } flg_t;

  // Operand index 1 is A / X, index 0 is B / Y.
  logic [NOPS-1:0][W-1:0] w_in, r_s1_op, w_hub, r_s2_op;
  cls_t [NOPS-1:0]        w_cls, r_s1_cls;
  flg_t [NOPS-1:0]        w_flg, r_s2_flg;
  logic                   r_s1_vld, r_s2_vld;
  logic                   w_s1_load, w_s2_load;

  assign w_in = {in_a, in_b};

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    logic [E-1:0] w_e;
    logic [M-1:0] w_f;
    logic         w_s2s;
    logic [E-1:0] w_s2e;
    logic [M-1:0] w_s2f;
    logic [W-1:0] w_pack;
    flg_t         w_fl;

    assign w_e = w_in[g][W-2:M];
    assign w_f = w_in[g][M-1:0];
    assign w_cls[g] = {(w_e == '0) && (w_f == '0),
                       (w_e == '0) && (w_f != '0),
                       (w_e == '1) && (w_f == '0),
                       (w_e == '1) && (w_f != '0),
                       w_e == {{(E-1){1'b1}}, 1'b0}};

    assign w_s2s = r_s1_op[g][W-1];
    assign w_s2e = r_s1_op[g][W-2:M];
    assign w_s2f = r_s1_op[g][M-1:0];

    // Largest finite IEEE exponent would rebias onto the reserved all-ones code.
    always_comb begin
      w_pack = {w_s2s, w_s2e + E'(1), w_s2f};
      w_fl   = '0;
      if (r_s1_cls[g].zero || r_s1_cls[g].sub) begin
        w_pack   = {w_s2s, {(W-1){1'b0}}};
        w_fl.flush = r_s1_cls[g].sub;
      end else if (r_s1_cls[g].nan) begin
        w_pack = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
        w_fl.nan = 1'b1;
      end else if (r_s1_cls[g].inf || r_s1_cls[g].maxe) begin
        w_pack = {w_s2s, {(W-1){1'b1}}};
        w_fl.sat = 1'b1;
      end
    end

    assign w_hub[g] = w_pack;
    assign w_flg[g] = w_fl;
  end

  assign w_s2_load = r_s1_vld & (~r_s2_vld | out_ready);
  assign in_ready  = ~r_s1_vld | w_s2_load;
  assign w_s1_load = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s1_op  <= '0;
      r_s1_cls <= '0;
      r_s2_op  <= '0;
      r_s2_flg <= '0;
    end else begin
      if (w_s1_load)      r_s1_vld <= 1'b1;
      else if (w_s2_load) r_s1_vld <= 1'b0;
      if (w_s2_load)      r_s2_vld <= 1'b1;
      else if (out_ready) r_s2_vld <= 1'b0;
      if (w_s1_load) begin
        r_s1_op  <= w_in;
        r_s1_cls <= w_cls;
      end
      if (w_s2_load) begin
        r_s2_op  <= w_hub;
        r_s2_flg <= w_flg;
      end
    end
  end

  assign out_valid = r_s2_vld;
  assign out_x     = r_s2_op[1];
  assign out_y     = r_s2_op[0];
  assign out_flags = {r_s2_flg[1], r_s2_flg[0]};

endmodule

// File: tb/tb_ieee_to_fphub_conv.sv
// Bench for ieee_to_fphub_conv (M=23, E=8): directed specials plus randomized
// streams with backpressure checked against a value-level reference model.
module tb_ieee_to_fphub_conv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_x, out_y;
  logic [5:0]  out_flags;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [5:0]  fl;
  } pair_t;

  pair_t q[$];

  ieee_to_fphub_conv #(.M(23), .E(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Returns {nan, sat, flush, hub_word}.
  function automatic logic [34:0] ref_conv(input logic [31:0] v);
    int          e;
    logic        s;
    logic [22:0] f;
    s = v[31];
    e = int'(v[30:23]);
    f = v[22:0];
    if (e == 0)              return {2'b00, (f != 0), s, 31'd0};
    if (e == 255 && f == 0)  return {3'b010, s, 31'h7FFFFFFF};
    if (e == 255)            return {3'b100, 32'h7FC00000};
    if (e + 1 == 255)        return {3'b010, s, 31'h7FFFFFFF};
    return {3'b000, s, 8'(e + 1), f};
  endfunction

  function automatic pair_t ref_pair(input logic [31:0] a, input logic [31:0] b);
    logic [34:0] ra, rb;
    pair_t p;
    ra = ref_conv(a);
    rb = ref_conv(b);
    p.x  = ra[31:0];
    p.y  = rb[31:0];
    p.fl = {ra[34:32], rb[34:32]};
    return p;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       r = {r[31], 31'd0};
      1:       r[30:23] = 8'h00;
      2:       r = {r[31], 8'hFF, 23'd0};
      3:       r[30:23] = 8'hFF;
      4:       r[30:23] = 8'hFE;
      5:       r[30:23] = 8'hFD;
      default: r[30:23] = 8'($urandom_range(1, 253));
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_x, out_y, out_flags} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b x=%h y=%h f=%b, want all zero",
               out_valid, out_x, out_y, out_flags);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6] = '{32'h3F800000, 32'h7F000000, 32'h7E800000,
                           32'h7FC00001, 32'h00000000, 32'h00800000};
    logic [31:0] vb[6] = '{32'hC0400000, 32'h7F7FFFFF, 32'hFF800000,
                           32'h80000001, 32'h00000001, 32'hFFFFFFFF};
    logic [31:0] ex[6] = '{32'h40000000, 32'h7FFFFFFF, 32'h7F000000,
                           32'h7FC00000, 32'h00000000, 32'h01000000};
    logic [31:0] ey[6] = '{32'hC0C00000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                           32'h80000000, 32'h00000000, 32'h7FC00000};
    logic [5:0]  ef[6] = '{6'b000000, 6'b010010, 6'b000010,
                           6'b100001, 6'b000001, 6'b000100};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({out_valid, out_x, out_y, out_flags} !== {1'b1, ex[i], ey[i], ef[i]}) begin
        n_err++;
        $display("FAIL directed[%0d]: got v=%b x=%h y=%h f=%b want v=1 x=%h y=%h f=%b",
                 i, out_valid, out_x, out_y, out_flags, ex[i], ey[i], ef[i]);
      end
    end
    @(negedge clk);
  endtask

  // Streams n pairs under a ready pattern, scoreboarding order, occupancy and stall stability.
  task automatic stream(input string nm, input int n, input bit use_pat, input bit gen_rand);
    int          sent = 0;
    int          cyc  = 0;
    bit          prev_stall = 0;
    logic [31:0] px = '0, py = '0;
    logic [5:0]  pf = '0;
    pair_t       e;
    bit          pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    while ((sent < n || q.size() != 0) && cyc < 600) begin
      @(negedge clk);
      out_ready = use_pat ? pat[cyc % 7] : ($urandom_range(0, 2) != 0);
      if (sent < n) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = gen_rand ? rand_op() : 32'h3F800000 + 32'(sent);
        in_b = gen_rand ? rand_op() : 32'h40000000 + 32'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_vec++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_err++;
        $display("FAIL %s_in_ready: cyc %0d got %b want %b (held %0d)",
                 nm, cyc, in_ready, ((q.size() < 2) || out_ready), q.size());
      end
      if (prev_stall) begin
        n_vec++;
        if ({out_valid, out_x, out_y, out_flags} !== {1'b1, px, py, pf}) begin
          n_err++;
          $display("FAIL %s_stall: cyc %0d got v=%b x=%h y=%h f=%b want v=1 x=%h y=%h f=%b",
                   nm, cyc, out_valid, out_x, out_y, out_flags, px, py, pf);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s_extra: cyc %0d unexpected pair x=%h y=%h", nm, cyc, out_x, out_y);
        end else begin
          e = q.pop_front();
          if ({out_x, out_y, out_flags} !== {e.x, e.y, e.fl}) begin
            n_err++;
            $display("FAIL %s_data: cyc %0d got x=%h y=%h f=%b want x=%h y=%h f=%b",
                     nm, cyc, out_x, out_y, out_flags, e.x, e.y, e.fl);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(ref_pair(in_a, in_b));
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      px = out_x; py = out_y; pf = out_flags;
      cyc++;
    end
    n_vec++;
    if (sent != n || q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: sent %0d of %0d, %0d still outstanding", nm, sent, n, q.size());
    end
    q.delete();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    stream("bp", 8, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    stream("rnd", 60, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int    acc = 0;
    pair_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = rand_op(); in_b = rand_op();
      #1;
      if (in_ready === 1'b1) acc++;
    end
    n_vec++;
    if (acc != 2) begin
      n_err++;
      $display("FAIL rstmid_capacity: accepted %0d want 2", acc);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_x, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_clear: got v=%b x=%h rdy=%b want v=0 x=0 rdy=1",
               out_valid, out_x, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'hC0400000; out_ready = 1'b1;
    e = ref_pair(in_a, in_b);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_early: out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({out_valid, out_x, out_y, out_flags} !== {1'b1, e.x, e.y, e.fl}) begin
      n_err++;
      $display("FAIL rstmid_after: got v=%b x=%h y=%h want v=1 x=%h y=%h",
               out_valid, out_x, out_y, e.x, e.y);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    pair_t exp_q[16];
    out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c < 16) begin
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op();
        exp_q[c] = ref_pair(in_a, in_b);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 16) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_in_ready: cyc %0d got %b want 1", c, in_ready);
        end
      end
      n_vec++;
      if (out_valid !== (c >= 2 && c < 18)) begin
        n_err++;
        $display("FAIL b2b_valid: cyc %0d got %b want %b", c, out_valid, (c >= 2 && c < 18));
      end else if (c >= 2 && c < 18) begin
        if ({out_x, out_y, out_flags} !== {exp_q[c-2].x, exp_q[c-2].y, exp_q[c-2].fl}) begin
          n_err++;
          $display("FAIL b2b_data: cyc %0d got x=%h y=%h f=%b want x=%h y=%h f=%b",
                   c, out_x, out_y, out_flags, exp_q[c-2].x, exp_q[c-2].y, exp_q[c-2].fl);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
